// File: rtl/sram_arb_pkg.sv
// Shared defaults and FSM state type for the SRAM port arbiter.
// The arbiter's parameters take their default sizes from here.
package sram_arb_pkg;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic {INIT, ARB} arb_state_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter.
// Per-requester fields are packed arrays indexed by requester number.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_port_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past last_grant
// and wraps, so the most recent winner has the lowest priority.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_grant
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_grant && req[cand]) begin
        grant[cand] = 1'b1;
        winner      = cand;
        any_grant   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one flop SRAM between NUM_REQ requesters: clears it after reset,
// then grants one access per cycle round-robin and returns read data a cycle later.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                NUM_REQ    = 2,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              driver_clk,
  input  logic              resetn,
  sram_port_arbiter_if.slave bus,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_add,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  init_addr_q, init_addr_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] arb_req, grant;
  logic [IDX_W-1:0]   winner;
  logic               any_grant;

  // Masking requests outside ARB keeps ready low for the whole sweep.
  assign arb_req = (state_q == ARB) ? bus.req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (arb_req),
    .last_grant (last_grant_q),
    .grant      (grant),
    .winner     (winner),
    .any_grant  (any_grant)
  );

  always_ff @(posedge driver_clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= INIT;
      init_addr_q  <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      rsp_valid_q  <= '0;
      init_done    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      init_done    <= (state_d == ARB);
    end
  end

  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = '0;
    mem_we       = 1'b0;
    mem_add      = '0;
    mem_wd       = '0;
    case (state_q)
      INIT: begin
        mem_we      = 1'b1;
        mem_add     = init_addr_q;
        mem_wd      = INIT_VALUE;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == ADDR_W'(DEPTH - 1)) state_d = ARB;
      end
      ARB: begin
        // Grant implies valid, so every grant here is a completed handshake.
        if (any_grant) begin
          mem_we       = bus.req_we[winner];
          mem_add      = bus.req_addr[winner];
          mem_wd       = bus.req_wdata[winner];
          last_grant_d = winner;
          if (!bus.req_we[winner]) rsp_valid_d = grant;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = (|rsp_valid_q) ? mem_rd : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter with a shadow-memory
// scoreboard; a model process predicts grants/responses, a monitor checks responses.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;
  localparam int N     = 2;
  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int DEPTH = DEF_DEPTH;

  logic          driver_clk = 1'b0;
  logic          resetn     = 1'b1;
  logic          init_done;
  logic [AW-1:0] mem_add;
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  sram_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .INIT_VALUE('0)) dut (
    .driver_clk (driver_clk),
    .resetn     (resetn),
    .bus        (bus.slave),
    .init_done  (init_done),
    .mem_add    (mem_add),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 driver_clk = ~driver_clk;

  // External SRAM: synchronous write, registered read.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge driver_clk) begin
    if (mem_we) sram[mem_add] <= mem_wd;
    mem_rd <= sram[mem_add];
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge driver_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t expq[$];

  logic [DW-1:0] shadow [DEPTH];
  int m_last = N - 1;
  int m_init = 0;

  // Reference model: sweep length, round-robin choice, shadow memory.
  always @(negedge driver_clk) begin : model
    int w;
    int c;
    logic [N-1:0] exp_rdy;
    if (resetn) begin
      expq.delete();
      m_last = N - 1;
      m_init = 0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      chk("reset_ready_done", {bus.req_ready, init_done}, '0);
    end else if (m_init < DEPTH) begin
      chk("init_sweep", {bus.req_ready, init_done, mem_we, mem_add, mem_wd},
          {{N{1'b0}}, 1'b0, 1'b1, AW'(m_init), {DW{1'b0}}});
      m_init++;
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (w < 0 && bus.req_valid[c]) w = c;
      end
      chk("init_done_high", init_done, 1);
      if (w < 0) begin
        chk("idle_outputs", {bus.req_ready, mem_we, mem_add, mem_wd}, '0);
      end else begin
        exp_rdy = '0;
        exp_rdy[w] = 1'b1;
        chk("grant", bus.req_ready, exp_rdy);
        chk("mem_drive", {mem_we, mem_add, mem_wd},
            {bus.req_we[w], bus.req_addr[w], bus.req_wdata[w]});
        m_last = w;
        if (bus.req_we[w]) shadow[bus.req_addr[w]] = bus.req_wdata[w];
        else expq.push_back('{due: cyc + 1, idx: w, data: shadow[bus.req_addr[w]]});
      end
    end
  end

  // Response monitor: every cycle either the oldest expected response is due or the bus is idle.
  always @(negedge driver_clk) begin : monitor
    rsp_t e;
    logic [N-1:0] exp_v;
    if (resetn) begin
      chk("rsp_in_reset", {bus.rsp_valid, bus.rsp_rdata}, '0);
    end else if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      exp_v = '0;
      exp_v[e.idx] = 1'b1;
      chk("rsp_valid", bus.rsp_valid, exp_v);
      chk("rsp_rdata", bus.rsp_rdata, e.data);
    end else begin
      chk("rsp_idle", {bus.rsp_valid, bus.rsp_rdata}, '0);
    end
  end

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_addr[0]  = a0;
    bus.req_addr[1]  = a1;
    bus.req_wdata[0] = d0;
    bus.req_wdata[1] = d1;
    @(posedge driver_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    @(posedge driver_clk);
    #1;
    idle(3);

    // Reset release, sweep, then read every location back as zero.
    resetn = 1'b0;
    idle(12);
    for (int a = 0; a < DEPTH; a++) step(2'b01, 2'b00, AW'(a), '0, '0, '0);
    idle(2);

    // Write then read the same address on the next cycle.
    step(2'b01, 2'b01, 3'd5, '0, 32'hDEADBEEF, '0);
    step(2'b01, 2'b00, 3'd5, '0, '0, '0);
    idle(2);

    // Two continuous readers alternate.
    for (int i = 0; i < 6; i++) step(2'b11, 2'b00, 3'd1, 3'd2, '0, '0);
    idle(2);

    // Requests held through reset and the sweep.
    resetn = 1'b1;
    step(2'b11, 2'b00, 3'd3, 3'd4, '0, '0);
    step(2'b11, 2'b00, 3'd3, 3'd4, '0, '0);
    resetn = 1'b0;
    for (int i = 0; i < 12; i++) step(2'b11, 2'b00, 3'd3, 3'd4, '0, '0);
    idle(2);

    // Reset right after a read is accepted drops the pending response.
    step(2'b10, 2'b11, 3'd6, 3'd2, '0, 32'h1234_5678);
    step(2'b10, 2'b00, 3'd6, 3'd2, '0, '0);
    resetn = 1'b1;
    idle(2);
    resetn = 1'b0;
    idle(10);
    step(2'b11, 2'b00, 3'd2, 3'd2, '0, '0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(N'($urandom_range(0, 3)), N'($urandom_range(0, 3)),
           AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
           DW'($urandom), DW'($urandom));
    idle(4);

    chk("queue_drained", 64'(expq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
